hic8_mode_sequencer: RTL and testbench

Upstream control stage for the 8-bit hybrid counter cell HIC8. It drives HIC8's mode, parallel-input and carry-in lines through a programmed sequence of load, increment and decrement phases, then holds. It also counts HIC8 carry-out events during the run. One command per run, accepted over a start/busy/done handshake.

---
 rtl/hic8_pkg.sv | 46 ++++
 rtl/hic8_phase_timer.sv | 28 ++
 rtl/hic8_mode_sequencer.sv | 111 +++++++++++
 tb/tb_hic8_mode_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hic8_pkg.sv
// Shared definitions for the HIC8 control stage.
//   MODE_* : HIC8 mode encodings driven on m.
//   state_t: sequencer phase encoding.
//   next_phase(): first phase after 'cur' whose length is nonzero, else IDLE.
//   mode_of()  : HIC8 mode that goes with each phase.
package hic8_pkg;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_DEC  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_INC  = 2'd2,
    S_DEC  = 2'd3
  } state_t;

  // Zero-length phases are skipped, so the successor depends on which
  // later phases actually have cycles to run.
  function automatic state_t next_phase(input state_t cur, input logic nz_load,
                                        input logic nz_inc, input logic nz_dec);
    state_t n;
    n = S_IDLE;
    case (cur)
      S_IDLE:  n = nz_load ? S_LOAD : nz_inc ? S_INC : nz_dec ? S_DEC : S_IDLE;
      S_LOAD:  n = nz_inc ? S_INC : nz_dec ? S_DEC : S_IDLE;
      S_INC:   n = nz_dec ? S_DEC : S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] mode_of(input state_t s);
    logic [1:0] md;
    case (s)
      S_LOAD:  md = MODE_LOAD;
      S_INC:   md = MODE_INC;
      S_DEC:   md = MODE_DEC;
      default: md = MODE_HOLD;
    endcase
    return md;
  endfunction

endpackage

// File: rtl/hic8_phase_timer.sv
// Loadable down-counter with zero flag, shared by all sequencer phases.
//   clk, rst  : clock, async active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded (phase length - 1)
//   dec       : decrement by one
//   zero      : count is 0
module hic8_phase_timer #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hic8_mode_sequencer.sv
// Drives HIC8 mode/pin/cin through LOAD -> INC -> DEC phases of programmed
// lengths, then returns to IDLE with a one-cycle done pulse. Counts HIC8
// carry-outs seen during INC/DEC (saturating).
//   clk, rst            : clock, async active-high reset
//   start               : command strobe, only sampled in IDLE
//   load_val, len_*     : command fields, latched at acceptance
//   cin_en              : drive cin=1 in INC/DEC
//   hic_cout            : HIC8 carry-out
//   m, pin, cin         : registered HIC8 controls
//   busy, done          : handshake status
//   cout_cnt            : carry-out events of the last run
module hic8_mode_sequencer
  import hic8_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] load_val,
  input  logic [LEN_W-1:0]  len_load,
  input  logic [LEN_W-1:0]  len_inc,
  input  logic [LEN_W-1:0]  len_dec,
  input  logic              cin_en,
  input  logic              hic_cout,
  output logic [1:0]        m,
  output logic [DATA_W-1:0] pin,
  output logic              cin,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cout_cnt
);

  state_t           state, nxt;
  logic [LEN_W-1:0] lat_load, lat_inc, lat_dec;
  logic             lat_cin;
  logic [LEN_W-1:0] ll, li, ld, nxt_len;
  logic             use_cin, advance, tmr_zero;

  // In IDLE the decision is made on the live command; mid-run only the
  // latched copy is consulted so input changes cannot disturb a run.
  always_comb begin
    ll      = lat_load;
    li      = lat_inc;
    ld      = lat_dec;
    use_cin = lat_cin;
    if (state == S_IDLE) begin
      ll      = len_load;
      li      = len_inc;
      ld      = len_dec;
      use_cin = cin_en;
    end
    nxt = next_phase(state, ll != '0, li != '0, ld != '0);
    case (nxt)
      S_LOAD:  nxt_len = ll;
      S_INC:   nxt_len = li;
      S_DEC:   nxt_len = ld;
      default: nxt_len = '0;
    endcase
  end

  assign advance = (state == S_IDLE) ? start : tmr_zero;

  hic8_phase_timer #(.LEN_W(LEN_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (advance && (nxt != S_IDLE)),
    .load_val (nxt_len - 1'b1),
    .dec      ((state != S_IDLE) && !tmr_zero),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      m        <= MODE_HOLD;
      pin      <= '0;
      cin      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cout_cnt <= '0;
      lat_load <= '0;
      lat_inc  <= '0;
      lat_dec  <= '0;
      lat_cin  <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == S_INC || state == S_DEC) && hic_cout && (cout_cnt != '1))
        cout_cnt <= cout_cnt + 1'b1;
      if (advance) begin
        state <= nxt;
        m     <= mode_of(nxt);
        cin   <= (nxt == S_INC || nxt == S_DEC) && use_cin;
        busy  <= (nxt != S_IDLE);
        done  <= (nxt == S_IDLE);
        if (state == S_IDLE) begin
          lat_load <= len_load;
          lat_inc  <= len_inc;
          lat_dec  <= len_dec;
          lat_cin  <= cin_en;
          cout_cnt <= '0;
          // pin holds its previous value unless the run has a LOAD phase
          if (nxt == S_LOAD) pin <= load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_hic8_mode_sequencer.sv
// Directed bench for hic8_mode_sequencer (CNT_W=4 to reach saturation).
module tb_hic8_mode_sequencer;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] load_val;
  logic [LEN_W-1:0]  len_load, len_inc, len_dec;
  logic              cin_en, hic_cout;
  logic [1:0]        m;
  logic [DATA_W-1:0] pin;
  logic              cin, busy, done;
  logic [CNT_W-1:0]  cout_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hic8_mode_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val),
    .len_load(len_load), .len_inc(len_inc), .len_dec(len_dec),
    .cin_en(cin_en), .hic_cout(hic_cout), .m(m), .pin(pin), .cin(cin),
    .busy(busy), .done(done), .cout_cnt(cout_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_val = '0; len_load = '0; len_inc = '0;
    len_dec = '0; cin_en = 1'b0; hic_cout = 1'b0;
    #3;
    chk("rst_m", m, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cout_cnt, 0);
    chk("rst_pin", pin, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Run 1: LOAD 3, INC 5, DEC 2, cin_en; restart attempt and field changes mid-run.
    load_val = 8'hA5; len_load = 3; len_inc = 5; len_dec = 2; cin_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("r1_m_c%0d", c), m, (c <= 3) ? 3 : (c <= 8) ? 1 : (c <= 10) ? 2 : 0);
      chk($sformatf("r1_cin_c%0d", c), cin, (c >= 4 && c <= 10) ? 1 : 0);
      chk($sformatf("r1_busy_c%0d", c), busy, (c <= 10) ? 1 : 0);
      chk($sformatf("r1_done_c%0d", c), done, (c == 11) ? 1 : 0);
      chk($sformatf("r1_pin_c%0d", c), pin, 8'hA5);
      // carry-outs in LOAD must not count; the one in DEC must
      hic_cout = (c <= 3 || c == 9);
      start = 1'b0;
      if (c == 5) begin
        start = 1'b1; load_val = 8'h3C; len_inc = 1; len_dec = 7; cin_en = 1'b0;
      end
      if (c == 11) begin
        chk("r1_cnt_end", cout_cnt, 1);
        // start on the done cycle: Run 2, LOAD skipped
        start = 1'b1; load_val = 8'h5A; len_load = 0; len_inc = 4; len_dec = 0;
        cin_en = 1'b0; hic_cout = 1'b0;
      end
      tick();
    end

    // Run 2: INC only, 4 cycles.
    for (int c = 1; c <= 6; c++) begin
      start = 1'b0;
      if (c == 1) chk("r2_cnt_cleared", cout_cnt, 0);
      chk($sformatf("r2_m_c%0d", c), m, (c <= 4) ? 1 : 0);
      chk($sformatf("r2_cin_c%0d", c), cin, 0);
      chk($sformatf("r2_busy_c%0d", c), busy, (c <= 4) ? 1 : 0);
      chk($sformatf("r2_done_c%0d", c), done, (c == 5) ? 1 : 0);
      chk($sformatf("r2_pin_c%0d", c), pin, 8'hA5);
      if (c == 5) chk("r2_cnt_end", cout_cnt, 2);
      hic_cout = (c == 2 || c == 3);
      tick();
    end

    // All lengths zero: no run, done one cycle after start.
    len_load = 0; len_inc = 0; len_dec = 0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("z_busy_c1", busy, 0);
    chk("z_done_c1", done, 1);
    chk("z_m_c1", m, 0);
    tick();
    chk("z_busy_c2", busy, 0);
    chk("z_done_c2", done, 0);

    // Saturation: LOAD 2, INC 15, DEC 15, hic_cout held high.
    load_val = 8'h0F; len_load = 2; len_inc = 15; len_dec = 15; cin_en = 1'b0;
    hic_cout = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 2)  chk("s_cnt_load", cout_cnt, 0);
      if (c == 17) chk("s_cnt_c17", cout_cnt, 14);
      if (c == 32) chk("s_m_c32", m, 2);
      if (c == 33) begin
        chk("s_done", done, 1);
        chk("s_cnt_sat", cout_cnt, 15);
      end
      if (c < 33) tick();
    end
    hic_cout = 1'b0;
    tick();
    chk("s_cnt_hold", cout_cnt, 15);

    // Reset mid-INC aborts with no done pulse.
    len_load = 0; len_inc = 10; len_dec = 0; hic_cout = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("a_m_c4", m, 1);
    chk("a_cnt_c4", cout_cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("a_m_rst", m, 0);
    chk("a_busy_rst", busy, 0);
    chk("a_cnt_rst", cout_cnt, 0);
    chk("a_done_rst", done, 0);
    tick();
    rst = 1'b0; hic_cout = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("a_done_after_c%0d", c), done, 0);
      chk($sformatf("a_m_after_c%0d", c), m, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
